multicycle_controller: RTL and testbench

- Control FSM that sits directly upstream of the dataPath block and drives every one of its control inputs.
- Consumes the opcode/func fields of the instruction register and the C/Z flags that dataPath produces.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.

---
 rtl/ctrl_pkg.sv | 33 +++
 rtl/branch_cond.sv | 18 +
 rtl/multicycle_controller.sv | 177 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode classes
// and the dataPath mux/ALU codes it drives.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_ALUI = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_MEM  = 3'b011;
  localparam logic [2:0] OP_BR   = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam logic [1:0] PCSRC_INC = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_SHR = 2'b01;
  localparam logic [1:0] WD_MEM = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;

endpackage

// File: rtl/branch_cond.sv
// Branch condition select: 00 Z, 01 !Z, 10 C, 11 !C.
module branch_cond (
  input  logic [1:0] func_i,
  input  logic       C_i,
  input  logic       Z_i,
  output logic       taken_o
);

  always_comb begin
    case (func_i)
      2'b00:   taken_o = Z_i;
      2'b01:   taken_o = !Z_i;
      2'b10:   taken_o = C_i;
      default: taken_o = !C_i;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for dataPath: FETCH/DECODE/EXEC/MEM/WB/HALT with a
// retired-instruction counter. Outputs decode combinationally from state.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int OPW   = 3,
  parameter int FW    = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcode,
  input  logic [FW-1:0]    func,
  input  logic             C,
  input  logic             Z,
  input  logic             memReady,
  output logic             pcEn,
  output logic             irWrite,
  output logic [1:0]       pcSrc,
  output logic             CEn,
  output logic             ZEn,
  output logic             regWrite,
  output logic             regFileReadRegister2Select,
  output logic             ALUBInputSelect,
  output logic [2:0]       ALUOperation,
  output logic [1:0]       regFileWriteDataSelect,
  output logic [1:0]       SHROOperation,
  output logic             DMMemWrite,
  output logic             DMMemRead,
  output logic             halted,
  output logic [CNT_W-1:0] instrCount
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op;
  logic             taken, retire;
  logic             pc_en, ir_wr, c_en, z_en, reg_wr, rs2_sel, alub_sel;
  logic             mem_wr, mem_rd, halt_st;
  logic [1:0]       pc_src, wd_sel, shro_op;
  logic [2:0]       alu_op;

  assign op = 3'(opcode);

  branch_cond u_branch_cond (
    .func_i  (func[1:0]),
    .C_i     (C),
    .Z_i     (Z),
    .taken_o (taken)
  );

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    pc_en    = 1'b0;
    ir_wr    = 1'b0;
    pc_src   = PCSRC_INC;
    c_en     = 1'b0;
    z_en     = 1'b0;
    reg_wr   = 1'b0;
    rs2_sel  = 1'b0;
    alub_sel = 1'b0;
    alu_op   = '0;
    wd_sel   = WD_ALU;
    shro_op  = '0;
    mem_wr   = 1'b0;
    mem_rd   = 1'b0;
    halt_st  = 1'b0;
    case (state_q)
      S_FETCH: begin
        pc_en   = 1'b1;
        ir_wr   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op == OP_NOP) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_ALU, OP_ALUI: begin
            alu_op   = 3'(func);
            alub_sel = (op == OP_ALUI);
            rs2_sel  = 1'b1;
            reg_wr   = 1'b1;
            wd_sel   = WD_ALU;
            c_en     = 1'b1;
            z_en     = 1'b1;
            retire   = 1'b1;
          end
          OP_SHR: begin
            shro_op = func[1:0];
            reg_wr  = 1'b1;
            wd_sel  = WD_SHR;
            c_en    = 1'b1;
            z_en    = 1'b1;
            retire  = 1'b1;
          end
          OP_MEM: begin
            alu_op   = ALU_ADD;
            alub_sel = 1'b1;
            state_d  = S_MEM;
          end
          OP_BR: begin
            pc_en  = taken;
            pc_src = PCSRC_BR;
            retire = 1'b1;
          end
          OP_JMP: begin
            pc_en  = 1'b1;
            pc_src = PCSRC_JMP;
            retire = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // Address path stays as set up in EXEC until memory answers.
        alu_op   = ALU_ADD;
        alub_sel = 1'b1;
        mem_wr   = func[0];
        mem_rd   = !func[0];
        if (memReady) begin
          if (func[0]) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_wr  = 1'b1;
        wd_sel  = WD_MEM;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  halt_st = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Reset state is FETCH, so gate everything with rst to keep strobes low.
  assign pcEn                       = pc_en & rst;
  assign irWrite                    = ir_wr & rst;
  assign pcSrc                      = rst ? pc_src : '0;
  assign CEn                        = c_en & rst;
  assign ZEn                        = z_en & rst;
  assign regWrite                   = reg_wr & rst;
  assign regFileReadRegister2Select = rs2_sel & rst;
  assign ALUBInputSelect            = alub_sel & rst;
  assign ALUOperation               = rst ? alu_op : '0;
  assign regFileWriteDataSelect     = rst ? wd_sel : '0;
  assign SHROOperation              = rst ? shro_op : '0;
  assign DMMemWrite                 = mem_wr & rst;
  assign DMMemRead                  = mem_rd & rst;
  assign halted                     = halt_st & rst;
  assign instrCount                 = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control words
// are queued by the stimulus and compared on the falling edge.
module tb_multicycle_controller;

  localparam int CW = 8;

  typedef struct packed {
    logic          pcEn, irWrite;
    logic [1:0]    pcSrc;
    logic          CEn, ZEn, regWrite, rs2, aluB;
    logic [2:0]    aluOp;
    logic [1:0]    wds, shro;
    logic          memWr, memRd, halted;
    logic [CW-1:0] cnt;
  } ctl_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    opcode = '0;
  logic [2:0]    func = '0;
  logic          C = 1'b0, Z = 1'b0, memReady = 1'b1;
  logic          pcEn, irWrite, CEn, ZEn, regWrite, rs2sel, aluB, memWr, memRd, halted;
  logic [1:0]    pcSrc, wds, shro;
  logic [2:0]    aluOp;
  logic [CW-1:0] instrCount;

  int            n_chk = 0, n_err = 0;
  logic [CW-1:0] exp_cnt = '0;
  ctl_t          sb[$];
  string         tq[$];

  always #5 clk = ~clk;

  multicycle_controller #(.OPW(3), .FW(3), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .C(C), .Z(Z),
    .memReady(memReady), .pcEn(pcEn), .irWrite(irWrite), .pcSrc(pcSrc),
    .CEn(CEn), .ZEn(ZEn), .regWrite(regWrite),
    .regFileReadRegister2Select(rs2sel), .ALUBInputSelect(aluB),
    .ALUOperation(aluOp), .regFileWriteDataSelect(wds), .SHROOperation(shro),
    .DMMemWrite(memWr), .DMMemRead(memRd), .halted(halted), .instrCount(instrCount)
  );

  function automatic ctl_t obs();
    return {pcEn, irWrite, pcSrc, CEn, ZEn, regWrite, rs2sel, aluB, aluOp,
            wds, shro, memWr, memRd, halted, instrCount};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) chk(tq.pop_front(), 32'(obs()), 32'(sb.pop_front()));
  end

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic step(input string tag, input ctl_t e);
    e.cnt = exp_cnt;
    sb.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode();
    ctl_t e;
    e = '0; e.pcEn = 1'b1; e.irWrite = 1'b1;
    step("fetch", e);
    e = '0;
    step("decode", e);
  endtask

  task automatic run_alu(input logic [2:0] op, input logic [2:0] f);
    ctl_t e;
    opcode = op; func = f; memReady = 1'b1;
    fetch_decode();
    e = '0; e.aluOp = f; e.aluB = (op == 3'b001); e.rs2 = 1'b1;
    e.regWrite = 1'b1; e.CEn = 1'b1; e.ZEn = 1'b1; e.wds = 2'b00;
    step("exec_alu", e);
    exp_cnt++;
  endtask

  task automatic run_shr(input logic [2:0] f);
    ctl_t e;
    opcode = 3'b010; func = f;
    fetch_decode();
    e = '0; e.shro = f[1:0]; e.regWrite = 1'b1; e.wds = 2'b01;
    e.CEn = 1'b1; e.ZEn = 1'b1;
    step("exec_shr", e);
    exp_cnt++;
  endtask

  task automatic run_br(input logic [2:0] f, input logic c, input logic z);
    ctl_t e;
    logic tk;
    opcode = 3'b100; func = f; C = c; Z = z;
    fetch_decode();
    case (f[1:0])
      2'b00:   tk = z;
      2'b01:   tk = !z;
      2'b10:   tk = c;
      default: tk = !c;
    endcase
    e = '0; e.pcEn = tk; e.pcSrc = 2'b01;
    step("exec_br", e);
    exp_cnt++;
  endtask

  task automatic run_jmp();
    ctl_t e;
    opcode = 3'b101; func = 3'b000;
    fetch_decode();
    e = '0; e.pcEn = 1'b1; e.pcSrc = 2'b10;
    step("exec_jmp", e);
    exp_cnt++;
  endtask

  task automatic run_nop();
    opcode = 3'b111;
    fetch_decode();
    exp_cnt++;
  endtask

  task automatic run_mem(input logic store, input int waits);
    ctl_t e;
    opcode = 3'b011; func = {2'b10, store}; memReady = 1'b0;
    fetch_decode();
    e = '0; e.aluOp = 3'b000; e.aluB = 1'b1; e.rs2 = 1'b0;
    step("exec_mem", e);
    for (int i = 0; i <= waits; i++) begin
      memReady = (i == waits);
      e = '0; e.aluB = 1'b1; e.memWr = store; e.memRd = !store;
      step(store ? "mem_st" : "mem_ld", e);
    end
    memReady = 1'b1;
    if (!store) begin
      e = '0; e.regWrite = 1'b1; e.wds = 2'b10;
      step("wb", e);
    end
    exp_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t e;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", 32'(obs()), 32'h0);
    rst = 1'b1;

    run_alu(3'b000, 3'b010);
    run_alu(3'b001, 3'b101);
    run_shr(3'b110);
    run_mem(1'b0, 2);
    run_mem(1'b1, 0);
    run_mem(1'b1, 1);
    run_br(3'b000, 1'b0, 1'b1);
    run_br(3'b000, 1'b0, 1'b0);
    run_br(3'b011, 1'b0, 1'b0);
    run_br(3'b111, 1'b1, 1'b0);
    run_br(3'b010, 1'b1, 1'b1);
    run_br(3'b001, 1'b1, 1'b0);
    run_jmp();
    run_nop();
    chk("count_mid", 32'(instrCount), 32'd14);

    // Reset pulled while a load is stalled in MEM.
    opcode = 3'b011; func = 3'b000; memReady = 1'b0;
    fetch_decode();
    e = '0; e.aluB = 1'b1;
    step("exec_mem2", e);
    #1;
    chk("mem_rd_stall", 32'(memRd), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid", 32'(obs()), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; memReady = 1'b1; exp_cnt = '0;
    run_alu(3'b000, 3'b011);

    // Halt: sticky, silent, not counted.
    opcode = 3'b110;
    fetch_decode();
    for (int i = 0; i < 20; i++) begin
      e = '0; e.halted = 1'b1;
      step("halt", e);
    end
    rst = 1'b0;
    #1;
    chk("rst_halt", 32'(obs()), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1; exp_cnt = '0;

    for (int i = 0; i < (1 << CW) - 1; i++) run_nop();
    chk("count_max", 32'(instrCount), 32'((1 << CW) - 1));
    run_nop();
    chk("count_wrap", 32'(instrCount), 32'h0);
    run_jmp();

    @(negedge clk);
    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
